// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, line geometry and word select
// for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int LINE_BITS      = 512;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_W       = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    FILL,
    WRITE,
    WDONE,
    RESP
  } state_t;

  // Word 0 sits in the line LSBs, matching dataMemory.
  function automatic logic [31:0] word_sel(
    input logic [LINE_BITS-1:0] line,
    input logic [3:0]           w
  );
    return line[{w, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_cpu_if: LSU request/response bundle (master=LSU, slave=cache).
// dcache_mem_if: dataMemory line-read / word-write bundle (master=cache).
interface dcache_cpu_if;
  logic        cpuReqValid;
  logic        cpuReqReady;
  logic        cpuReqWrite;
  logic [31:0] cpuReqAddr;
  logic [31:0] cpuReqWData;
  logic        cpuRespValid;
  logic [31:0] cpuRespData;
  logic        cpuInvalidate;

  modport master (
    output cpuReqValid, cpuReqWrite,
    output cpuReqAddr, cpuReqWData,
    output cpuInvalidate,
    input  cpuReqReady, cpuRespValid,
    input  cpuRespData
  );

  modport slave (
    input  cpuReqValid, cpuReqWrite,
    input  cpuReqAddr, cpuReqWData,
    input  cpuInvalidate,
    output cpuReqReady, cpuRespValid,
    output cpuRespData
  );
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;
  logic [31:0]          memReadAddress;
  logic                 memReadDone;
  logic [LINE_BITS-1:0] memReadData;
  logic [31:0]          memWriteAddress;
  logic                 memWriteRequest;
  logic [31:0]          memWriteData;
  logic                 memWriteDone;

  modport master (
    output memReadAddress,
    input  memReadDone, memReadData,
    output memWriteAddress,
    output memWriteRequest, memWriteData,
    input  memWriteDone
  );

  modport slave (
    input  memReadAddress,
    output memReadDone, memReadData,
    input  memWriteAddress,
    input  memWriteRequest, memWriteData,
    output memWriteDone
  );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: tag/valid/data arrays, combinational read, one write
// port (full-line fill or single-word update) and bulk valid clear.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - OFFSET_W - INDEX_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [INDEX_W-1:0]   rd_index,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 we,
  input  logic                 we_line,
  input  logic [INDEX_W-1:0]   w_index,
  input  logic [TAG_W-1:0]     w_tag,
  input  logic [LINE_BITS-1:0] w_line,
  input  logic [3:0]           w_word,
  input  logic [31:0]          w_data,
  input  logic                 clr
);

  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tags  [NUM_SETS];
  logic [LINE_BITS-1:0] lines [NUM_SETS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (we && we_line) begin
      valid[w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      if (we_line) begin
        tags[w_index]  <= w_tag;
        lines[w_index] <= w_line;
      end else begin
        lines[w_index][{w_word, 5'b0} +: 32] <= w_data;
      end
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: blocking direct-mapped write-through, no-write-allocate
// data cache. Ports: clock, reset_n (async low), cpu (dcache_cpu_if.slave),
// mem (dcache_mem_if.master); statHits/statMisses/statWrites with DCACHE_STATS_EN.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 4
) (
  input logic          clock,
  input logic          reset_n,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  statHits,
  output logic [31:0]  statMisses,
  output logic [31:0]  statWrites
`endif
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;

  state_t      state;
  logic        req_write;
  logic [31:2] req_addr;
  logic [31:0] req_wdata;
  logic        toggle;

  logic [3:0]           word;
  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit;
  logic                 we;
  logic                 we_line;
  logic                 clr;

  assign word = req_addr[5:2];
  assign idx  = req_addr[OFFSET_W +: INDEX_W];
  assign tag  = req_addr[31 -: TAG_W];
  assign hit  = rd_valid && (rd_tag == tag);

  assign we_line = (state == FILL);
  assign we = (state == LOOKUP && req_write && hit)
           || (state == FILL && mem.memReadDone);
  assign clr = (state == IDLE) && cpu.cpuInvalidate;

  dcache_line_store #(
    .NUM_SETS (NUM_SETS),
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_index (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (we),
    .we_line  (we_line),
    .w_index  (idx),
    .w_tag    (tag),
    .w_line   (mem.memReadData),
    .w_word   (word),
    .w_data   (req_wdata),
    .clr      (clr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      req_write           <= 1'b0;
      req_addr            <= '0;
      req_wdata           <= '0;
      toggle              <= 1'b0;
      cpu.cpuReqReady     <= 1'b1;
      cpu.cpuRespValid    <= 1'b0;
      cpu.cpuRespData     <= '0;
      mem.memReadAddress  <= '0;
      mem.memWriteAddress <= '0;
      mem.memWriteData    <= '0;
      mem.memWriteRequest <= 1'b0;
    end else begin
      cpu.cpuRespValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu.cpuReqValid) begin
            req_write       <= cpu.cpuReqWrite;
            req_addr        <= cpu.cpuReqAddr[31:2];
            req_wdata       <= cpu.cpuReqWData;
            cpu.cpuReqReady <= 1'b0;
            state           <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_write)  state <= WRITE;
          else if (hit)   state <= RESP;
          else            state <= FETCH;
        end
        FETCH: begin
          // Bit 0 flips each fetch so a refetch of the same line
          // still presents a new address to dataMemory.
          mem.memReadAddress <= {req_addr[31:6], 5'b0, ~toggle};
          toggle             <= ~toggle;
          state              <= FILL;
        end
        FILL: begin
          if (mem.memReadDone) state <= RESP;
        end
        WRITE: begin
          mem.memWriteAddress <= {req_addr, 2'b0};
          mem.memWriteData    <= req_wdata;
          mem.memWriteRequest <= 1'b1;
          state               <= WDONE;
        end
        WDONE: begin
          if (mem.memWriteDone) begin
            mem.memWriteRequest <= 1'b0;
            state               <= RESP;
          end
        end
        RESP: begin
          cpu.cpuRespValid <= 1'b1;
          cpu.cpuRespData  <= req_write ? '0
                            : word_sel(rd_line, word);
          cpu.cpuReqReady  <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      statHits   <= '0;
      statMisses <= '0;
      statWrites <= '0;
    end else if (state == LOOKUP) begin
      if (req_write)  statWrites <= statWrites + 32'd1;
      else if (hit)   statHits   <= statHits + 32'd1;
      else            statMisses <= statMisses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed vector table plus randomized traffic
// against a set/tag reference model and a behavioural dataMemory.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int NS = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dcache_cpu_if cpu_if ();
  dcache_mem_if mem_if ();

`ifdef DCACHE_STATS_EN
  logic [31:0] statHits, statMisses, statWrites;
`endif

  dcache_controller #(.NUM_SETS(NS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cpu     (cpu_if),
    .mem     (mem_if)
`ifdef DCACHE_STATS_EN
    ,
    .statHits   (statHits),
    .statMisses (statMisses),
    .statWrites (statWrites)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int lat_r = 2;
  int lat_w = 2;
  int rd_wait = 0;
  int wr_wait = 0;
  int fetches = 0;
  int writes = 0;
  logic [31:0] prev_ra = '0;
  logic [31:0] last_fa = '0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic        prev_req = 1'b0;

  bit          mvalid [NS];
  int unsigned mtag   [NS];
  bit          exp_toggle = 1'b0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  int          exp_writes = 0;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          inv;
    bit          exp_miss;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] iw(input int i);
    logic [31:0] v;
    v = i;
    return 32'hC0DE0000 ^ (v * 32'h00010003);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural dataMemory, reacting on the falling edge.
  always @(negedge clock) begin
    logic [9:0] wi;
    if (!reset_n) begin
      prev_ra = mem_if.memReadAddress;
    end
    if (reset_n && mem_if.memReadAddress !== prev_ra) begin
      prev_ra = mem_if.memReadAddress;
      mem_if.memReadDone = 1'b0;
      rd_wait = lat_r;
      fetches++;
      last_fa = prev_ra;
    end else if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        for (int i = 0; i < 16; i++) begin
          wi = {prev_ra[11:6], 4'(i)};
          mem_if.memReadData[i*32 +: 32] = mem[wi];
        end
        mem_if.memReadDone = 1'b1;
      end
    end
    if (!reset_n) begin
      prev_req = 1'b0;
      wr_wait = 0;
      mem_if.memWriteDone = 1'b0;
    end else begin
      if (mem_if.memWriteRequest && !prev_req) begin
        wr_wait = lat_w;
        writes++;
        last_wa = mem_if.memWriteAddress;
        last_wd = mem_if.memWriteData;
        mem_if.memWriteDone = 1'b0;
      end else if (mem_if.memWriteRequest && wr_wait > 0) begin
        wr_wait--;
        if (wr_wait == 0) begin
          mem[last_wa[11:2]] = last_wd;
          mem_if.memWriteDone = 1'b1;
        end
      end else if (!mem_if.memWriteRequest) begin
        mem_if.memWriteDone = 1'b0;
      end
      prev_req = mem_if.memWriteRequest;
    end
  end

  // Reference: loads always return memory contents (write-through);
  // hit/miss comes from a per-set tag record, stores never allocate.
  task automatic model(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit inv,
                       output bit miss, output logic [31:0] data);
    int unsigned idx;
    int unsigned tg;
    idx = (a / 64) % NS;
    tg  = a / (64 * NS);
    if (inv) foreach (mvalid[k]) mvalid[k] = 1'b0;
    if (w) begin
      ref_mem[a[11:2]] = d;
      miss = 1'b0;
      data = '0;
      exp_writes++;
    end else begin
      miss = !(mvalid[idx] && mtag[idx] == tg);
      if (miss) begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        exp_misses++;
      end else begin
        exp_hits++;
      end
      data = ref_mem[a[11:2]];
    end
  endtask

  task automatic do_req(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit inv,
                        output logic [31:0] got, output bit fetched);
    int f0, w0, cyc, lat;
    f0 = fetches;
    w0 = writes;
    got = 'x;
    fetched = 1'b0;
    cyc = 0;
    @(negedge clock);
    while (!cpu_if.cpuReqReady && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("req_ready", {31'b0, cpu_if.cpuReqReady}, 32'd1);
    if (!cpu_if.cpuReqReady) return;
    cpu_if.cpuReqValid   = 1'b1;
    cpu_if.cpuReqWrite   = w;
    cpu_if.cpuReqAddr    = a;
    cpu_if.cpuReqWData   = d;
    cpu_if.cpuInvalidate = inv;
    @(posedge clock);
    #1;
    cpu_if.cpuReqValid   = 1'b0;
    cpu_if.cpuInvalidate = 1'b0;
    cyc = 1;
    while (!cpu_if.cpuRespValid && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("resp_seen", {31'b0, cpu_if.cpuRespValid}, 32'd1);
    if (!cpu_if.cpuRespValid) return;
    got = cpu_if.cpuRespData;
    fetched = (fetches != f0);
    check("fetch_count_le1", (fetches - f0) <= 1, 32'd1);
    check("write_count", writes - w0, {31'b0, w});
    lat = fetched ? lat_r + 5 : (w ? lat_w + 5 : 3);
    check("latency", cyc, lat);
    if (fetched) begin
      check("fetch_addr", last_fa,
            {a[31:6], 5'b0, ~exp_toggle});
      exp_toggle = ~exp_toggle;
    end
    if (w) begin
      check("wr_addr", last_wa, {a[31:2], 2'b0});
      check("wr_data", last_wd, d);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {31'b0, cpu_if.cpuReqReady}, 32'd1);
    check({tag, "_rvalid"}, {31'b0, cpu_if.cpuRespValid}, 32'd0);
    check({tag, "_rdata"}, cpu_if.cpuRespData, 32'd0);
    check({tag, "_raddr"}, mem_if.memReadAddress, 32'd0);
    check({tag, "_waddr"}, mem_if.memWriteAddress, 32'd0);
    check({tag, "_wdata"}, mem_if.memWriteData, 32'd0);
    check({tag, "_wreq"}, {31'b0, mem_if.memWriteRequest}, 32'd0);
  endtask

  task automatic add(input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit inv,
                     input bit m, input logic [31:0] x);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.inv = inv;
    v.exp_miss = m; v.exp_data = x;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, xd;
    bit          f, xm;
    int          bad;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = iw(i);
      ref_mem[i] = iw(i);
    end
    foreach (mvalid[k]) mvalid[k] = 1'b0;
    mem_if.memReadDone   = 1'b0;
    mem_if.memReadData   = '0;
    mem_if.memWriteDone  = 1'b0;
    cpu_if.cpuReqValid   = 1'b0;
    cpu_if.cpuReqWrite   = 1'b0;
    cpu_if.cpuReqAddr    = '0;
    cpu_if.cpuReqWData   = '0;
    cpu_if.cpuInvalidate = 1'b0;

    repeat (2) @(negedge clock);
    check_reset("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;

    add(0, 32'h44,  '0,           0, 1, iw(17));
    add(0, 32'h48,  '0,           0, 0, iw(18));
    add(1, 32'h48,  32'hDEADBEEF, 0, 0, 32'h0);
    add(0, 32'h48,  '0,           0, 0, 32'hDEADBEEF);
    add(1, 32'h80,  32'h12345678, 0, 0, 32'h0);
    add(0, 32'h80,  '0,           0, 1, 32'h12345678);
    add(0, 32'h00,  '0,           0, 1, iw(0));
    add(0, 32'h100, '0,           0, 1, iw(64));
    add(0, 32'h00,  '0,           0, 1, iw(0));
    add(0, 32'h04,  '0,           0, 0, iw(1));
    add(0, 32'h44,  '0,           1, 1, iw(17));
    add(0, 32'h3C,  '0,           0, 1, iw(15));

    lat_r = 2;
    lat_w = 3;
    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].inv, xm, xd);
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].inv, got, f);
      check("tbl_data", got, tbl[i].exp_data);
      check("tbl_miss", {31'b0, f}, {31'b0, tbl[i].exp_miss});
    end

    // Reset asserted while the controller waits in FILL.
    lat_r = 8;
    @(negedge clock);
    cpu_if.cpuReqValid = 1'b1;
    cpu_if.cpuReqWrite = 1'b0;
    cpu_if.cpuReqAddr  = 32'h1C0;
    @(posedge clock);
    #1 cpu_if.cpuReqValid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    #1 check_reset("fill_rst");
    foreach (mvalid[k]) mvalid[k] = 1'b0;
    exp_toggle = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    exp_writes = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (cpu_if.cpuRespValid || !cpu_if.cpuReqReady) bad++;
    end
    check("late_done_ignored", bad, 0);
    lat_r = 3;
    model(0, 32'h1C0, '0, 0, xm, xd);
    do_req(0, 32'h1C0, '0, 0, got, f);
    check("post_rst_data", got, iw(32'h70));
    check("post_rst_miss", {31'b0, f}, 32'd1);

    for (int n = 0; n < 150; n++) begin
      bit          w, inv;
      logic [31:0] a, d;
      w     = ($urandom % 3) == 0;
      a     = $urandom_range(0, 255) * 4;
      d     = $urandom;
      inv   = ($urandom % 20) == 0;
      lat_r = $urandom_range(1, 5);
      lat_w = $urandom_range(1, 4);
      model(w, a, d, inv, xm, xd);
      do_req(w, a, d, inv, got, f);
      check("rnd_data", got, xd);
      check("rnd_miss", {31'b0, f}, {31'b0, xm});
    end

`ifdef DCACHE_STATS_EN
    check("stat_hits", statHits, exp_hits);
    check("stat_misses", statMisses, exp_misses);
    check("stat_writes", statWrites, exp_writes);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
